mem_fetch_unit: RTL

Memory access and instruction-register stage for the multicycle MIPS core, directly upstream of the main controller. It turns the controller's IRWrite/MemWrite/data-read strobes into transactions on a single unified memory bus with a request/grant/read-valid handshake. Fetched words land in the instruction register (IR) or the memory data register (MDR). The IR is decoded into the opcode, funct and register fields that the controller and register file consume. A busy flag lets the controller hold its state while memory has wait states.

---
 rtl/mips_pkg.sv | 36 +++
 rtl/mem_fetch_unit_if.sv | 34 +++
 rtl/mem_timeout_ctr.sv | 30 +++
 rtl/mem_fetch_unit.sv | 134 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct codes, IR field positions,
// and the memory-fetch FSM state encoding.
package mips_pkg;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } fsm_state_t;

  typedef enum logic {
    TGT_IR,
    TGT_MDR
  } tgt_t;

endpackage

// File: rtl/mem_fetch_unit_if.sv
// Unified memory bus: request/grant for the command phase,
// rvalid/rdata for the read-return phase.
interface mem_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              bus_req_o;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic              bus_gnt_i;
  logic              bus_rvalid_i;
  logic [DATA_W-1:0] bus_rdata_i;

  modport master (
    output bus_req_o,
    output bus_we_o,
    output bus_addr_o,
    output bus_wdata_o,
    input  bus_gnt_i,
    input  bus_rvalid_i,
    input  bus_rdata_i
  );

  modport slave (
    input  bus_req_o,
    input  bus_we_o,
    input  bus_addr_o,
    input  bus_wdata_o,
    output bus_gnt_i,
    output bus_rvalid_i,
    output bus_rdata_i
  );
endinterface

// File: rtl/mem_timeout_ctr.sv
// Access watchdog: counts cycles while enabled, flags when the
// count reaches TIMEOUT-1, and holds there until cleared.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && !expired_o)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_fetch_unit.sv
// Multicycle MIPS memory stage: drives the unified bus for
// fetch/load/store, holds IR and MDR, and decodes IR fields.
module mem_fetch_unit
  import mips_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] alu_out_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              IorD_i,
  input  logic              IRWrite_i,
  input  logic              MemWrite_i,
  input  logic              dread_i,
  mem_fetch_unit_if.master  bus,
  output logic [DATA_W-1:0] instr_o,
  output logic [5:0]        opcode_o,
  output logic [5:0]        funct_o,
  output logic [4:0]        rs_o,
  output logic [4:0]        rt_o,
  output logic [4:0]        rd_o,
  output logic [15:0]       imm_o,
  output logic [DATA_W-1:0] mdr_o,
  output logic              busy_o,
  output logic              err_o
);
  fsm_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  tgt_t              tgt_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] mdr_q;
  logic              err_q;

  logic cmd;
  logic expired;
  logic in_req;
  logic in_wait;
  logic done_hit;
  logic rd_hit;
  logic to_hit;

  assign cmd     = MemWrite_i | IRWrite_i | dread_i;
  assign in_req  = (state_q == REQ);
  assign in_wait = (state_q == WAIT);

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q == IDLE),
    .en_i      (in_req | in_wait),
    .expired_o (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cmd) state_d = REQ;
      REQ: begin
        if (bus.bus_gnt_i)
          state_d = (we_q || bus.bus_rvalid_i) ? DONE : WAIT;
        else if (expired)
          state_d = DONE;
      end
      WAIT: if (bus.bus_rvalid_i || expired) state_d = DONE;
      DONE: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.bus_req_o   = in_req;
    bus.bus_we_o    = in_req & we_q;
    bus.bus_addr_o  = addr_q;
    bus.bus_wdata_o = wdata_q;
    busy_o          = in_req | in_wait;
    done_hit        = (in_req & bus.bus_gnt_i)
                    | (in_wait & bus.bus_rvalid_i);
    rd_hit          = ~we_q & bus.bus_rvalid_i
                    & ((in_req & bus.bus_gnt_i) | in_wait);
    to_hit          = busy_o & expired & ~done_hit;
  end

  // Lower-priority strobes are simply dropped on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      tgt_q   <= TGT_IR;
    end else if (state_q == IDLE && cmd) begin
      addr_q  <= IorD_i ? alu_out_i : pc_i;
      wdata_q <= wdata_i;
      we_q    <= MemWrite_i;
      tgt_q   <= IRWrite_i ? TGT_IR : TGT_MDR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q  <= '0;
      mdr_q <= '0;
    end else if (rd_hit) begin
      if (tgt_q == TGT_IR) ir_q  <= bus.bus_rdata_i;
      else                 mdr_q <= bus.bus_rdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         err_q <= 1'b0;
    else if (to_hit) err_q <= 1'b1;
  end

  assign instr_o  = ir_q;
  assign mdr_o    = mdr_q;
  assign err_o    = err_q;
  assign opcode_o = ir_q[OP_HI:OP_LO];
  assign rs_o     = ir_q[RS_HI:RS_LO];
  assign rt_o     = ir_q[RT_HI:RT_LO];
  assign rd_o     = ir_q[RD_HI:RD_LO];
  assign funct_o  = ir_q[FN_HI:FN_LO];
  assign imm_o    = ir_q[IMM_HI:IMM_LO];
endmodule
